// File: rtl/fx2qspi_pkg.sv
// rtl/fx2qspi_pkg.sv - shared QSPI mode, direction and FSM definitions
package fx2qspi_pkg;

  localparam logic [1:0] MODE_SPI = 2'b00;
  localparam logic [1:0] MODE_DPI = 2'b01;
  localparam logic [1:0] MODE_QPI = 2'b10;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // The reserved encoding behaves as plain SPI
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_SPI : m;
  endfunction

  function automatic logic [3:0] beats_per_byte(input logic [1:0] m);
    case (m)
      MODE_DPI: return 4'd4;
      MODE_QPI: return 4'd2;
      default:  return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/qspi_target_if.sv
// rtl/qspi_target_if.sv - host-facing pads and byte streams of the QSPI target
interface qspi_target_if;

  logic [1:0] cfg_mode;
  logic       cfg_dir;
  logic       SPI_CS;
  logic       SPI_CLK;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  cfg_mode, cfg_dir, SPI_CS, SPI_CLK, io_in, tx_data, tx_valid,
    output io_out, io_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_err, busy
  );

  modport master (
    output cfg_mode, cfg_dir, SPI_CS, SPI_CLK, io_in, tx_data, tx_valid,
    input  io_out, io_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_err, busy
  );

endinterface

// File: rtl/qspi_sync_edge.sv
// rtl/qspi_sync_edge.sv - multi-stage synchroniser with rise/fall pulses
module qspi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign w_q    = r_sync[STAGES-1];
  assign o_rise = w_q & ~r_prev;
  assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/qspi_target.sv
// rtl/qspi_target.sv - oversampled mode-3 QSPI responder in SPI/DPI/QPI widths
module qspi_target
  import fx2qspi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input logic          FX_IFCLK,
  input logic          RST_N,
  qspi_target_if.slave bus
);

  logic       w_cs_rise, w_cs_fall, w_clk_rise, w_clk_fall;
  logic [3:0] r_io_sync [SYNC_STAGES];
  logic [3:0] w_io;

  state_t     r_state;
  logic [1:0] r_mode;
  logic       r_dir;
  logic [2:0] r_beat;
  logic [7:0] r_rx_sh, r_rx_data, r_tx_sh, r_hold;
  logic       r_hold_full, r_tx_ready;
  logic       r_rx_valid, r_tx_underrun, r_frame_err, r_busy;
  logic [3:0] r_io_out, r_oe;
  logic       w_last, w_rx_active, w_tx_active;
  logic [7:0] w_rx_next, w_load_byte;

  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .i_clk(FX_IFCLK), .i_rst_n(RST_N), .i_d(bus.SPI_CS),
    .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
    .i_clk(FX_IFCLK), .i_rst_n(RST_N), .i_d(bus.SPI_CLK),
    .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  // Same depth as the CLK synchroniser so data lines up with the detected edge
  always_ff @(posedge FX_IFCLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_io_sync[i] <= 4'h0;
    end else begin
      r_io_sync[0] <= bus.io_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_io_sync[i] <= r_io_sync[i-1];
    end
  end
  assign w_io = r_io_sync[SYNC_STAGES-1];

  function automatic logic [7:0] rx_shift(input logic [1:0] m, input logic [7:0] sh,
                                          input logic [3:0] io);
    case (m)
      MODE_DPI: return {sh[5:0], io[1:0]};
      MODE_QPI: return {sh[3:0], io};
      default:  return {sh[6:0], io[0]};
    endcase
  endfunction

  function automatic logic [3:0] tx_beat(input logic [1:0] m, input logic [7:0] b);
    case (m)
      MODE_DPI: return {2'b00, b[7:6]};
      MODE_QPI: return b[7:4];
      default:  return {2'b00, b[7], 1'b0};
    endcase
  endfunction

  function automatic logic [7:0] tx_shl(input logic [1:0] m, input logic [7:0] b);
    case (m)
      MODE_DPI: return {b[5:0], 2'b00};
      MODE_QPI: return {b[3:0], 4'h0};
      default:  return {b[6:0], 1'b0};
    endcase
  endfunction

  function automatic logic [3:0] oe_for(input logic [1:0] m, input logic d);
    if (m == MODE_SPI)           return 4'b0010;
    if (m == MODE_DPI && d == DIR_IN) return 4'b0011;
    if (m == MODE_QPI && d == DIR_IN) return 4'b1111;
    return 4'b0000;
  endfunction

  assign w_last      = (r_beat == 3'(beats_per_byte(r_mode) - 4'd1));
  assign w_rx_active = (r_mode == MODE_SPI) || (r_dir == DIR_OUT);
  assign w_tx_active = (r_mode == MODE_SPI) || (r_dir == DIR_IN);
  assign w_rx_next   = rx_shift(r_mode, r_rx_sh, w_io);
  assign w_load_byte = r_hold_full ? r_hold : IDLE_BYTE;

  always_ff @(posedge FX_IFCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_SPI;
      r_dir         <= DIR_OUT;
      r_beat        <= 3'd0;
      r_rx_sh       <= 8'h00;
      r_rx_data     <= 8'h00;
      r_tx_sh       <= 8'h00;
      r_hold        <= 8'h00;
      r_hold_full   <= 1'b0;
      r_tx_ready    <= 1'b1;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
      r_io_out      <= 4'h0;
      r_oe          <= 4'h0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;

      // A full register has tx_ready low, so an offer can never collide with its load
      if (bus.tx_valid && r_tx_ready) begin
        r_hold      <= bus.tx_data;
        r_hold_full <= 1'b1;
        r_tx_ready  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_mode  <= norm_mode(bus.cfg_mode);
            r_dir   <= bus.cfg_dir;
            r_oe    <= oe_for(norm_mode(bus.cfg_mode), bus.cfg_dir);
            r_beat  <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= ST_SEL;
          end
        end
        ST_SEL, ST_SHIFT: begin
          if (w_cs_rise) begin
            r_frame_err <= (r_beat != 3'd0);
            r_beat      <= 3'd0;
            r_busy      <= 1'b0;
            r_oe        <= 4'h0;
            r_state     <= ST_IDLE;
          end else begin
            if (w_clk_rise && r_state == ST_SHIFT) begin
              if (w_rx_active) r_rx_sh <= w_rx_next;
              if (w_last) begin
                r_beat <= 3'd0;
                if (w_rx_active) begin
                  r_rx_data  <= w_rx_next;
                  r_rx_valid <= 1'b1;
                end
              end else begin
                r_beat <= r_beat + 3'd1;
              end
            end
            if (w_clk_fall) begin
              r_state <= ST_SHIFT;
              if (w_tx_active) begin
                if (r_beat == 3'd0) begin
                  r_io_out <= tx_beat(r_mode, w_load_byte);
                  r_tx_sh  <= tx_shl(r_mode, w_load_byte);
                  if (r_hold_full) begin
                    r_hold_full <= 1'b0;
                    r_tx_ready  <= 1'b1;
                  end else begin
                    r_tx_underrun <= 1'b1;
                  end
                end else begin
                  r_io_out <= tx_beat(r_mode, r_tx_sh);
                  r_tx_sh  <= tx_shl(r_mode, r_tx_sh);
                end
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pads are released in the very cycle the deselect is seen
  assign bus.io_oe       = w_cs_rise ? 4'h0 : r_oe;
  assign bus.io_out      = r_io_out;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.frame_err   = r_frame_err;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_qspi_target.sv
// tb/tb_qspi_target.sv - directed scoreboard bench for the QSPI target
module tb_qspi_target;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qspi_target_if bus();

  qspi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .FX_IFCLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_rxv = 0;
  int n_ferr = 0;
  int n_urun = 0;
  logic [7:0] q_rx[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.tx_underrun === 1'b1) n_urun++;
    if (bus.rx_valid === 1'b1) begin
      n_rxv++;
      if (q_rx.size() == 0) check("rx_unexpected_pending", 32'(q_rx.size()), 32'd1);
      else check("rx_data", 32'(bus.rx_data), 32'(q_rx.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] b);
    int k = 0;
    while (bus.tx_ready !== 1'b1 && k < 40) begin
      cyc(1);
      k++;
    end
    check("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic cs_low(input logic [1:0] m, input logic d);
    bus.cfg_mode = m;
    bus.cfg_dir  = d;
    bus.SPI_CS   = 1'b0;
    cyc(HALF);
  endtask

  task automatic cs_high();
    cyc(HALF);
    bus.SPI_CS = 1'b1;
    cyc(HALF);
  endtask

  // Host side of mode 3: drive on the falling edge, sample target just before rising
  task automatic xfer(input logic [1:0] m, input logic [7:0] mosi, input int nbeats,
                      input bit chk, input logic [7:0] exp_miso,
                      input bit do_offer, input logic [7:0] nxt);
    logic [7:0] sh;
    logic [7:0] miso;
    sh   = mosi;
    miso = 8'h00;
    for (int b = 0; b < nbeats; b++) begin
      bus.SPI_CLK = 1'b0;
      if (m == 2'b10) begin
        bus.io_in = sh[7:4];
        sh = {sh[3:0], 4'h0};
      end else if (m == 2'b01) begin
        bus.io_in = {2'b00, sh[7:6]};
        sh = {sh[5:0], 2'b00};
      end else begin
        bus.io_in = {3'b000, sh[7]};
        sh = {sh[6:0], 1'b0};
      end
      cyc(HALF);
      if (m == 2'b10)      miso = {miso[3:0], bus.io_out};
      else if (m == 2'b01) miso = {miso[5:0], bus.io_out[1:0]};
      else                 miso = {miso[6:0], bus.io_out[1]};
      bus.SPI_CLK = 1'b1;
      cyc(HALF);
      if (b == 0 && do_offer) offer(nxt);
    end
    if (chk) check("miso", 32'(miso), 32'(exp_miso));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int r0, u0, f0;
    bus.cfg_mode = 2'b00;
    bus.cfg_dir  = 1'b0;
    bus.SPI_CS   = 1'b1;
    bus.SPI_CLK  = 1'b1;
    bus.io_in    = 4'h0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    cyc(5);

    check("rst_io_oe", 32'(bus.io_oe), 32'h0);
    check("rst_io_out", 32'(bus.io_out), 32'h0);
    check("rst_rx_data", 32'(bus.rx_data), 32'h0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'h1);
    check("rst_tx_underrun", 32'(bus.tx_underrun), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    cyc(5);

    // SPI receive, no tx data so MISO underruns
    r0 = n_rxv; u0 = n_urun;
    q_rx.push_back(8'hA5);
    cs_low(2'b00, 1'b0);
    check("spi_busy", 32'(bus.busy), 32'h1);
    check("spi_oe_start", 32'(bus.io_oe), 32'h2);
    xfer(2'b00, 8'hA5, 8, 1'b1, 8'hFF, 1'b0, 8'h00);
    check("spi_oe_end", 32'(bus.io_oe), 32'h2);
    cs_high();
    check("spi_rx_count", 32'(n_rxv - r0), 32'd1);
    check("spi_busy_off", 32'(bus.busy), 32'h0);
    check("spi_oe_off", 32'(bus.io_oe), 32'h0);
    check("spi_urun", 32'(n_urun - u0), 32'd1);

    // QPI transmit of a preloaded byte
    r0 = n_rxv; u0 = n_urun;
    offer(8'h3C);
    check("qpi_ready_low", 32'(bus.tx_ready), 32'h0);
    cs_low(2'b10, 1'b1);
    check("qpi_oe", 32'(bus.io_oe), 32'hF);
    xfer(2'b10, 8'h00, 1, 1'b1, 8'h03, 1'b0, 8'h00);
    check("qpi_ready_back", 32'(bus.tx_ready), 32'h1);
    xfer(2'b10, 8'h00, 1, 1'b1, 8'h0C, 1'b0, 8'h00);
    cs_high();
    check("qpi_urun", 32'(n_urun - u0), 32'd0);
    check("qpi_rx_count", 32'(n_rxv - r0), 32'd0);

    // DPI receive followed by a truncated byte
    r0 = n_rxv; u0 = n_urun; f0 = n_ferr;
    q_rx.push_back(8'h96);
    cs_low(2'b01, 1'b0);
    check("dpi_oe", 32'(bus.io_oe), 32'h0);
    xfer(2'b01, 8'h96, 4, 1'b0, 8'h00, 1'b0, 8'h00);
    xfer(2'b01, 8'hC0, 2, 1'b0, 8'h00, 1'b0, 8'h00);
    cs_high();
    check("dpi_rx_count", 32'(n_rxv - r0), 32'd1);
    check("dpi_frame_err", 32'(n_ferr - f0), 32'd1);
    check("dpi_urun", 32'(n_urun - u0), 32'd0);

    // Two-byte SPI frame with nothing to send
    u0 = n_urun;
    q_rx.push_back(8'h12);
    q_rx.push_back(8'h34);
    cs_low(2'b00, 1'b0);
    xfer(2'b00, 8'h12, 8, 1'b1, 8'hFF, 1'b0, 8'h00);
    xfer(2'b00, 8'h34, 8, 1'b1, 8'hFF, 1'b0, 8'h00);
    cs_high();
    check("urun_count", 32'(n_urun - u0), 32'd2);

    // SPI full duplex, next tx byte offered during each byte
    r0 = n_rxv; u0 = n_urun; f0 = n_ferr;
    offer(8'h10);
    q_rx.push_back(8'h01);
    q_rx.push_back(8'h02);
    q_rx.push_back(8'h03);
    cs_low(2'b11, 1'b0);
    check("fd_oe_mode3", 32'(bus.io_oe), 32'h2);
    xfer(2'b00, 8'h01, 8, 1'b1, 8'h10, 1'b1, 8'h20);
    xfer(2'b00, 8'h02, 8, 1'b1, 8'h20, 1'b1, 8'h30);
    xfer(2'b00, 8'h03, 8, 1'b1, 8'h30, 1'b0, 8'h00);
    cs_high();
    check("fd_rx_count", 32'(n_rxv - r0), 32'd3);
    check("fd_urun", 32'(n_urun - u0), 32'd0);
    check("fd_frame_err", 32'(n_ferr - f0), 32'd0);

    // Reset during beat 5 of an SPI byte, then a clean frame
    r0 = n_rxv;
    cs_low(2'b00, 1'b0);
    xfer(2'b00, 8'hC3, 4, 1'b0, 8'h00, 1'b0, 8'h00);
    bus.SPI_CLK = 1'b0;
    bus.io_in   = 4'h1;
    cyc(4);
    check("rst_mid_oe_before", 32'(bus.io_oe), 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(bus.io_oe), 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    cyc(HALF);
    bus.SPI_CLK = 1'b1;
    bus.SPI_CS  = 1'b1;
    cyc(HALF);
    check("rst_mid_rx_count", 32'(n_rxv - r0), 32'd0);
    rst_n = 1'b1;
    cyc(HALF);
    r0 = n_rxv; f0 = n_ferr;
    q_rx.push_back(8'h5A);
    cs_low(2'b00, 1'b0);
    xfer(2'b00, 8'h5A, 8, 1'b1, 8'hFF, 1'b0, 8'h00);
    cs_high();
    check("post_rst_rx_count", 32'(n_rxv - r0), 32'd1);
    check("post_rst_rx_data", 32'(bus.rx_data), 32'h5A);
    check("post_rst_frame_err", 32'(n_ferr - f0), 32'd0);

    check("rx_queue_drained", 32'(q_rx.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/qspi_target.md
Name: qspi_target

Overview:
- QSPI responder (target) for the other end of the FX2 slave-FIFO QSPI bridge. Implements SPI mode 3 in SPI, DPI and QPI widths, MSB first.
- Oversamples SPI_CS and SPI_CLK in the FX_IFCLK domain. Deserialises host-driven bytes onto a pulse stream and serialises a byte stream back onto the IO lines.
- Used as an on-board loopback/flash-emulation target and as the bench responder for the bridge.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on SPI_CS, SPI_CLK and IO inputs.
- IDLE_BYTE, 8'hFF: byte shifted out when no tx byte is held (underrun).

Ports:
- FX_IFCLK  in  1  sole clock; all logic is on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- cfg_mode  in  2  00 SPI, 01 DPI, 10 QPI, 11 treated as SPI. Latched at frame start.
- cfg_dir  in  1  0 host->target, 1 target->host. Latched at frame start.
- SPI_CS  in  1  active-low chip select from the host.
- SPI_CLK  in  1  host clock, idles high.
- io_in  in  4  pad inputs IO3..IO0 (HOLD, WP, MISO, MOSI).
- io_out  out  4  pad output values.
- io_oe  out  4  per-pad output enable, active high.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates; no backpressure.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid&tx_ready.
- tx_underrun  out  1  one-cycle pulse when IDLE_BYTE is substituted.
- frame_err  out  1  one-cycle pulse when CS rises with a partial byte.
- busy  out  1  high while the synchronised CS is low.

Behaviour:
- Reset values: io_out=0, io_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_err=0, busy=0. Holding register empty, FSM in IDLE.
- Synchronisation: SPI_CS, SPI_CLK and io_in each pass through SYNC_STAGES flip-flops. Edges are detected from the synchronised CLK against its previous value.
- Timing requirement: each SPI_CLK phase must last at least SYNC_STAGES+2 FX_IFCLK cycles.
- States:
  - IDLE: CS high. Transition to SEL on synchronised CS fall, latching cfg_mode and cfg_dir.
  - SEL: CS low, no edge yet. First falling edge -> SHIFT (load tx shifter, drive first beat).
  - SHIFT: rising edge samples, falling edge drives.
  - CS rise from SEL or SHIFT returns to IDLE.
- Beats per byte: SPI 8, DPI 4, QPI 2. A beat counter counts rising edges and wraps to 0 after the last beat of a byte.
- Rx path (rising edges), MSB first:
  - SPI shifts in io_in[0].
  - DPI shifts in {io_in[1],io_in[0]}.
  - QPI shifts in io_in[3:0].
  - On the last beat, rx_data takes the assembled byte and rx_valid pulses on the next cycle.
  - Rx is active in SPI mode regardless of direction, and in DPI/QPI only when dir=0.
- Tx path (falling edges):
  - On the first falling edge of each byte, the shifter loads from the holding register if it is full (tx_ready rises next cycle). Otherwise it loads IDLE_BYTE and pulses tx_underrun.
  - Subsequent falling edges advance the shifter: SPI drives io_out[1], DPI io_out[1:0], QPI io_out[3:0].
  - Tx is active in SPI mode always, and in DPI/QPI only when dir=1.
- Output enables while busy:
  - SPI: io_oe=0010.
  - DPI with dir=1: 0011.
  - QPI with dir=1: 1111.
  - Otherwise: 0000.
  - io_oe drops to 0000 on the same cycle the synchronised CS rises.
- CS rise mid-byte (beat counter nonzero): discard partial rx, no rx_valid, pulse frame_err, clear the beat counter. The holding register is retained.
- Synchronised CS rise and CLK rising edge detected in the same cycle: CS wins, the edge is ignored.
- tx_valid during a load cycle: the load takes priority. tx_ready is low that cycle; the offer is accepted on the next cycle.
- RST_N assertion mid-frame: immediate return to reset values, including dropping io_oe. After release, the target waits for a fresh CS fall before acting.

Decomposition:
- Shared package fx2qspi_pkg holds MODE_SPI/MODE_DPI/MODE_QPI, DIR_OUT/DIR_IN, the FSM state encoding, and a beats-per-mode function.
- One sub-module, qspi_sync_edge: a SYNC_STAGES synchroniser with rise/fall pulse outputs, instantiated for CS and CLK.

Test Plan:
- SPI rx: CS low, MOSI carries 0xA5 over 8 clocks -> a single rx_valid with rx_data=0xA5; io_oe=0010 throughout.
- QPI tx: tx_data=0x3C preloaded, dir=1, 2 clocks -> nibbles 0x3 then 0xC sampled on the rising edges; io_oe=1111; tx_ready re-asserts after the first fall.
- DPI rx: 0x96 followed by 2 beats of a second byte, then CS high -> one rx_valid (0x96), one frame_err, no second rx_valid.
- Underrun: SPI frame with no tx_valid -> MISO reads 0xFF and tx_underrun pulses once per byte.
- SPI full duplex, 3 bytes: MOSI 0x01/0x02/0x03 with tx 0x10/0x20/0x30 -> rx 01,02,03 and MISO 10,20,30, byte-aligned.
- RST_N low during beat 5 of a SPI byte -> io_oe=0 in the same cycle and no rx_valid. A new frame after release receives 0x5A correctly.
